// File: rtl/letreiro_scan_controller.sv
// Scan/mode sequencer for the 5x7 LED marquee: row scan, shift strobe, blink gating.
// Mode requests from the ch0/ch1 switches are committed only at frame boundaries.
module letreiro_scan_controller #(
    parameter int SCAN_DIV         = 50000,
    parameter int FRAMES_PER_SHIFT = 24,
    parameter int BLINK_FRAMES     = 12
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       ch0,
    input  logic       ch1,
    output logic [4:0] row_n,
    output logic       col_en,
    output logic       shift_en,
    output logic       shift_dir,
    output logic       frame_start,
    output logic [1:0] mode,
    output logic       rele
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (FRAMES_PER_SHIFT > 1) ? $clog2(FRAMES_PER_SHIFT) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {
        MODE_STOP     = 2'b00,
        MODE_SCROLL_L = 2'b01,
        MODE_SCROLL_R = 2'b10,
        MODE_BLINK    = 2'b11
    } mode_e;

    logic [1:0]    ch_meta_q, ch_sync_q;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [4:0]    row_n_q, row_n_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    mode_e         mode_q, mode_d;
    logic          col_en_q, col_en_d;
    logic          shift_en_q, shift_en_d;
    logic          shift_dir_q, shift_dir_d;
    logic          frame_start_q, frame_start_d;
    logic          rele_q, rele_d;

    mode_e         req;
    logic          slot_edge;
    logic          frame_edge;

    assign req        = mode_e'(ch_sync_q);
    assign slot_edge  = (pcnt_q == PW'(SCAN_DIV - 1));
    // row_n_q[4] low means L5 is being driven, i.e. the last row of the frame
    assign frame_edge = slot_edge && !row_n_q[4];

    // The switches are asynchronous to CLK, so each passes two flops before use.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ch_meta_q <= '0;
            ch_sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep the two synchronizer stages distinct flops.
            ch_meta_q <= {ch1, ch0};
            ch_sync_q <= ch_meta_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pcnt_q        <= '0;
            row_n_q       <= 5'b11110;
            fcnt_q        <= '0;
            bcnt_q        <= '0;
            mode_q        <= MODE_STOP;
            col_en_q      <= 1'b0;
            shift_en_q    <= 1'b0;
            shift_dir_q   <= 1'b0;
            frame_start_q <= 1'b0;
            rele_q        <= 1'b0;
        end else begin
            pcnt_q        <= pcnt_d;
            row_n_q       <= row_n_d;
            fcnt_q        <= fcnt_d;
            bcnt_q        <= bcnt_d;
            mode_q        <= mode_d;
            col_en_q      <= col_en_d;
            shift_en_q    <= shift_en_d;
            shift_dir_q   <= shift_dir_d;
            frame_start_q <= frame_start_d;
            rele_q        <= rele_d;
        end
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        pcnt_d        = slot_edge ? '0 : pcnt_q + 1'b1;
        row_n_d       = slot_edge ? {row_n_q[3:0], row_n_q[4]} : row_n_q;
        fcnt_d        = fcnt_q;
        bcnt_d        = bcnt_q;
        mode_d        = mode_q;
        col_en_d      = col_en_q;
        shift_en_d    = 1'b0;
        shift_dir_d   = shift_dir_q;
        frame_start_d = frame_edge;
        rele_d        = rele_q;

        if (frame_edge) begin
            if (req != mode_q) begin
                // A commit swallows any shift or blink toggle due at this boundary.
                mode_d      = req;
                fcnt_d      = '0;
                bcnt_d      = '0;
                col_en_d    = (req != MODE_STOP);
                shift_dir_d = (req == MODE_SCROLL_R);
            end else begin
                case (mode_q)
                    MODE_SCROLL_L, MODE_SCROLL_R: begin
                        if (fcnt_q == FW'(FRAMES_PER_SHIFT - 1)) begin
                            fcnt_d     = '0;
                            shift_en_d = 1'b1;
                            rele_d     = ~rele_q;
                        end else begin
                            fcnt_d = fcnt_q + 1'b1;
                        end
                    end
                    MODE_BLINK: begin
                        if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                            bcnt_d   = '0;
                            col_en_d = ~col_en_q;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign row_n       = row_n_q;
    assign col_en      = col_en_q;
    assign shift_en    = shift_en_q;
    assign shift_dir   = shift_dir_q;
    assign frame_start = frame_start_q;
    assign mode        = mode_q;
    assign rele        = rele_q;

endmodule

// File: doc/letreiro_scan_controller.md
# letreiro_scan_controller

Timing and mode sequencer for the 5×7 LED marquee. From the single system clock it generates the row-scan drive for L1..L5, a one-cycle shift strobe and direction for the five row shift registers, and the column-enable/blink gating. It replaces the free-running frequency dividers and sits between the ch0/ch1 switches, the row shift registers and the matrix driver. Mode changes are taken only at frame boundaries so the display never tears.

## Interface
- SCAN_DIV, 50000: CLK cycles per row slot (≥2)
- FRAMES_PER_SHIFT, 24: full frames between shift strobes (≥1)
- BLINK_FRAMES, 12: frames per blink half-period (≥1)

- CLK  in  1  system clock; the block's only clock
- RST_N  in  1  asynchronous reset, active-low
- ch0, ch1  in  1 each  asynchronous mode switches; mode request = {ch1,ch0}
- row_n  out  5  active-low one-hot row drive; bit0 = L1
- col_en  out  1  1 = matrix driver may light columns; 0 = blank
- shift_en  out  1  one-cycle shift strobe to row registers
- shift_dir  out  1  0 = left, 1 = right
- frame_start  out  1  one-cycle pulse in the first cycle of row 0
- mode  out  2  currently committed mode
- rele  out  1  toggles on every shift_en

## Operation
- Input sync: ch0/ch1 each pass through a 2-flop synchronizer; the synchronized pair is the requested mode.
- Prescaler: pcnt counts 0..SCAN_DIV-1 and wraps. A slot edge is a clock edge with pcnt = SCAN_DIV-1.
- Row counter: row 0..4 advances on every slot edge and wraps 4→0. row_n = ~(1<<row).
- Frame boundary: slot edge with row = 4.
- Mode states (mode register):
  - 00 STOP: col_en=0; no shift_en; frame and blink counters held at 0.
  - 01 SCROLL_L: col_en=1, shift_dir=0.
  - 10 SCROLL_R: col_en=1, shift_dir=1.
  - 11 BLINK: no shift_en; col_en toggles every BLINK_FRAMES frames.
- At each frame boundary:
  - If the requested mode ≠ mode: commit the new mode; clear fcnt and bcnt; col_en gets the new mode's entry value (1 for 01/10/11, 0 for 00); shift_dir updates. No shift_en at this boundary. Mode change takes priority over a coinciding fcnt wrap.
  - Otherwise in 01/10: fcnt counts 0..FRAMES_PER_SHIFT-1. On wrap, shift_en=1 and rele toggles.
  - Otherwise in 11: bcnt counts 0..BLINK_FRAMES-1. On wrap, col_en inverts.
- shift_dir changes only at frame boundaries and is stable for the full cycle in which shift_en is high.

## Timing
- All outputs are registered. pcnt, row, frame_start, shift_en, mode, col_en, shift_dir and rele all update on the same edge.
- Reset values (asserted asynchronously, held while RST_N=0):
  - row_n=5'b11110, pcnt=0, fcnt=0, bcnt=0
  - mode=00, col_en=0, shift_en=0, shift_dir=0, frame_start=0, rele=0
  - synchronizer flops = 0
- Frame = 5·SCAN_DIV cycles. After reset release, row 0 holds for SCAN_DIV cycles. The first frame boundary edge is at cycle 5·SCAN_DIV−1, counting the first post-release cycle as 0.
- frame_start and shift_en are high exactly one cycle: the first cycle of row 0 after a wrap.
- Switch-to-commit latency: 2 cycles of sync, then up to one frame; worst case 5·SCAN_DIV+2 cycles.
- In steady scroll mode, the shift period is FRAMES_PER_SHIFT frames; the first shift comes FRAMES_PER_SHIFT frames after the commit.
- Reset mid-frame: all state returns to its reset value immediately, with no completion of a pending shift. Operation restarts from row 0.
- Switch glitches shorter than one frame that resolve before a boundary have no effect.

## Test plan
Bench parameters: SCAN_DIV=2, FRAMES_PER_SHIFT=3, BLINK_FRAMES=2 (frame = 10 cycles).
- Reset, then ch=01 held: row_n steps 11110→11101→11011→10111→01111, 2 cycles each. frame_start at cycles 10, 20, 30… mode=01 from cycle 10. shift_en at cycles 40, 70, 100 with shift_dir=0; rele toggles at each.
- ch=10 from reset: same cadence as above, shift_dir=1 from cycle 10.
- ch=00 held: col_en=0 throughout; shift_en never high; rele constant 0.
- ch=11: col_en=1 at cycle 10, 0 at cycle 30, 1 at cycle 50. No shift_en.
- Mode change mid-frame: scroll mode 01, ch→10 during row 2 of a frame. Required response:
  - mode and shift_dir change only at the next boundary;
  - no shift_en at that boundary, even if fcnt would have wrapped;
  - the next shift comes 3 frames later.
- Reset in the middle of row 3 while shift_en is pending: outputs take their reset values in the same cycle RST_N falls, with no clock edge needed. After release, row 0 is active and the first frame_start comes 10 cycles later.
